// File: rtl/move_arbiter.sv
// Two-requester cursor arbiter that hands the mover one owner per VGA frame.
// Optional MOVE_ARB_TIMEOUT_EN pre-empts an owner idle for IDLE_FRAMES frames.
module move_arbiter #(
  parameter logic [7:0] IDLE_FRAMES = 8'd60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       req0,
  input  logic [3:0] dir0,
  input  logic       req1,
  input  logic [3:0] dir1,
  output logic       move_en,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t     state, state_nxt;
  logic       vsync_q;
  logic       last_served;
  logic       frame;
  logic       timeout;
  logic [3:0] dir0_c, dir1_c, new_dir;

  // Opposing directions in the same word cancel each other out.
  function automatic logic [3:0] cancel(input logic [3:0] d);
    logic [3:0] c;
    c = d;
    if (d[3] && d[2]) c[3:2] = 2'b00;
    if (d[1] && d[0]) c[1:0] = 2'b00;
    return c;
  endfunction

  assign frame  = !vsync && vsync_q;
  assign dir0_c = cancel(dir0);
  assign dir1_c = cancel(dir1);

`ifdef MOVE_ARB_TIMEOUT_EN
  logic [7:0] idle_cnt, idle_cnt_nxt, cnt_inc;
  logic [3:0] own_dir;

  always_comb begin
    own_dir = (state == OWN0) ? dir0_c : (state == OWN1) ? dir1_c : 4'd0;
    cnt_inc = (idle_cnt >= IDLE_FRAMES) ? IDLE_FRAMES : idle_cnt + 8'd1;
    timeout = (state != IDLE) && (own_dir == 4'd0) && (cnt_inc >= IDLE_FRAMES);
  end

  // Counter restarts on activity or whenever ownership changes hands.
  always_comb begin
    if ((state == IDLE) || (state_nxt != state) || (own_dir != 4'd0))
      idle_cnt_nxt = 8'd0;
    else
      idle_cnt_nxt = cnt_inc;
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last_served ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0)                state_nxt = req1 ? OWN1 : IDLE;
        else if (timeout && req1) state_nxt = OWN1;
      end
      OWN1: begin
        if (!req1)                state_nxt = req0 ? OWN0 : IDLE;
        else if (timeout && req0) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (state_nxt)
      OWN0:    new_dir = dir0_c;
      OWN1:    new_dir = dir1_c;
      default: new_dir = 4'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vsync_q     <= 1'b0;
      last_served <= 1'b1;
      grant       <= 2'b00;
      busy        <= 1'b0;
      move_en     <= 1'b0;
      {up, down, left, right} <= 4'd0;
`ifdef MOVE_ARB_TIMEOUT_EN
      idle_cnt    <= 8'd0;
`endif
    end else begin
      vsync_q <= vsync;
      if (frame) begin
        state   <= state_nxt;
        grant   <= {state_nxt == OWN1, state_nxt == OWN0};
        busy    <= (state_nxt != IDLE);
        move_en <= (state_nxt != IDLE);
        {up, down, left, right} <= new_dir;
        if ((state_nxt != state) && (state_nxt != IDLE))
          last_served <= (state_nxt == OWN1);
`ifdef MOVE_ARB_TIMEOUT_EN
        idle_cnt <= idle_cnt_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_move_arbiter.sv
// Directed plus randomized checks of move_arbiter against a frame-level owner model.
module tb_move_arbiter;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst, vsync, req0, req1;
  logic [3:0] dir0, dir1;
  logic       move_en, up, down, left, right, busy;
  logic [1:0] grant;

  int n_pass  = 0;
  int n_total = 0;

  // Model: owner is -1 (nobody), 0 or 1.
  int         owner = -1;
  int         last  = 1;
  int         cnt   = 0;
  logic [8:0] exp_q = '0;

  move_arbiter #(.IDLE_FRAMES(8'(N))) dut (
    .clk(clk), .rst(rst), .vsync(vsync),
    .req0(req0), .dir0(dir0), .req1(req1), .dir1(dir1),
    .move_en(move_en), .up(up), .down(down), .left(left), .right(right),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] observed();
    return {grant, busy, move_en, up, down, left, right};
  endfunction

  function automatic logic [3:0] effective(input logic [3:0] d);
    logic u, dn, l, r;
    u  = d[3] && !d[2];
    dn = d[2] && !d[3];
    l  = d[1] && !d[0];
    r  = d[0] && !d[1];
    return {u, dn, l, r};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic model_boundary();
    int         nxt;
    logic       r_own, r_oth;
    logic [3:0] d_own;
    if (owner < 0) begin
      if (req0 && req1) nxt = 1 - last;
      else if (req0)    nxt = 0;
      else if (req1)    nxt = 1;
      else              nxt = -1;
    end else begin
      r_own = (owner == 0) ? req0 : req1;
      r_oth = (owner == 0) ? req1 : req0;
      d_own = effective((owner == 0) ? dir0 : dir1);
      if (!r_own) begin
        nxt = r_oth ? 1 - owner : -1;
      end else begin
        nxt = owner;
`ifdef MOVE_ARB_TIMEOUT_EN
        if (d_own == 4'd0) begin
          cnt = (cnt + 1 > N) ? N : cnt + 1;
          if (cnt >= N && r_oth) nxt = 1 - owner;
        end else begin
          cnt = 0;
        end
`endif
      end
    end
    if (nxt != owner) begin
      cnt = 0;
      if (nxt >= 0) last = nxt;
    end
    owner = nxt;
    if (owner < 0) exp_q = '0;
    else exp_q = {owner == 1, owner == 0, 2'b11, effective((owner == 0) ? dir0 : dir1)};
  endtask

  // One frame: vsync high for a while, then the falling edge; sample after the boundary.
  task automatic frame(input string tag);
    @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    model_boundary();
    @(posedge clk);
    @(negedge clk);
    check(tag, observed(), exp_q);
  endtask

  task automatic set_in(input logic r0, input logic [3:0] d0, input logic r1, input logic [3:0] d1);
    req0 = r0; dir0 = d0; req1 = r1; dir1 = d1;
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0;
    set_in(1'b0, 4'd0, 1'b0, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", observed(), 9'd0);
    rst = 1'b0;

    frame("idle_f1");
    frame("idle_f2");
    check("idle_const", observed(), 9'd0);

    // Tie at the first boundary goes to requester 0, then hand-over and alternation.
    set_in(1'b1, 4'd0, 1'b1, 4'd0);
    frame("tie_first");
    check("tie_first_grant", {7'd0, grant}, {7'd0, 2'b01});
    set_in(1'b0, 4'd0, 1'b1, 4'd0);
    frame("handover");
    check("handover_grant", {7'd0, grant}, {7'd0, 2'b10});
    set_in(1'b0, 4'd0, 1'b0, 4'd0);
    frame("to_idle");
    set_in(1'b1, 4'd0, 1'b1, 4'd0);
    frame("tie_second");
    check("tie_second_grant", {7'd0, grant}, {7'd0, 2'b01});
    set_in(1'b0, 4'd0, 1'b0, 4'd0);
    frame("to_idle2");
    set_in(1'b1, 4'd0, 1'b1, 4'd0);
    frame("tie_third");
    check("tie_third_grant", {7'd0, grant}, {7'd0, 2'b10});

    // Cancellation of opposing directions.
    set_in(1'b0, 4'd0, 1'b0, 4'd0);
    frame("to_idle3");
    set_in(1'b1, 4'b1100, 1'b0, 4'd0);
    frame("cancel_ud");
    check("cancel_ud_const", observed(), 9'b01_1_1_0000);
    dir0 = 4'b1010;
    frame("up_left");
    check("up_left_const", observed(), 9'b01_1_1_1010);

    // Mid-frame changes must not reach the outputs.
    @(negedge clk);
    dir0 = 4'b0101;
    repeat (3) @(negedge clk);
    check("midframe_low", observed(), exp_q);
    vsync = 1'b1;
    dir0 = 4'b0001;
    repeat (3) @(negedge clk);
    check("midframe_high", observed(), 9'b01_1_1_1010);
    vsync = 1'b0;
    model_boundary();
    @(posedge clk);
    @(negedge clk);
    check("after_midframe", observed(), exp_q);

    // Idle owner with a waiting competitor.
    set_in(1'b0, 4'd0, 1'b0, 4'd0);
    frame("to_idle4");
    set_in(1'b1, 4'd0, 1'b0, 4'd0);
    frame("own0");
    req1 = 1'b1;
    frame("idle_b1");
    frame("idle_b2");
    frame("idle_b3");
`ifdef MOVE_ARB_TIMEOUT_EN
    check("timeout_grant", {7'd0, grant}, {7'd0, 2'b10});
`else
    check("no_timeout_grant", {7'd0, grant}, {7'd0, 2'b01});
`endif

    // Randomized frames, with occasional mid-frame noise that is overwritten before the boundary.
    for (int i = 0; i < 200; i++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      dir0 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      dir1 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      frame($sformatf("rand_%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        dir0 = 4'($urandom);
        @(negedge clk);
        check($sformatf("rand_hold_%0d", i), observed(), exp_q);
      end
    end

    // Reset asserted on a boundary cycle dominates it.
    set_in(1'b1, 4'b1000, 1'b1, 4'b0010);
    @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_on_boundary", observed(), 9'd0);
    owner = -1; last = 1; cnt = 0; exp_q = '0;
    rst = 1'b0;
    frame("post_reset_tie");
    check("post_reset_grant", {7'd0, grant}, {7'd0, 2'b01});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
